// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-outstanding valid/ready to APB requester with a wait-state watchdog
module apb_master_bridge #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);
  localparam logic [1:0] IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2;
  localparam logic [7:0] LAST = 8'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);
  localparam bit WD = TIMEOUT != 0;
  logic [1:0] state;
  logic [7:0] wait_cnt;
  logic       abort;
  assign req_ready = state == IDLE;
  assign abort = WD && wait_cnt == LAST;
  // Sequence SETUP/ACCESS phases, count wait states and emit the response strobe
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state     <= IDLE;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      wait_cnt  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          state   <= SETUP;
          psel    <= 1'b1;
          penable <= 1'b0;
          pwrite  <= req_write;
          paddr   <= req_addr;
          pwdata  <= req_wdata;
        end
        SETUP: begin
          state    <= ACCESS;
          penable  <= 1'b1;
          wait_cnt <= '0;
        end
        ACCESS: if (pready || abort) begin
          state     <= IDLE;
          psel      <= 1'b0;
          penable   <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_err   <= !pready;
          rsp_rdata <= (pready && !pwrite) ? prdata : '0;
        end else if (WD) begin
          wait_cnt <= wait_cnt + 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
